// File: rtl/shift_unit_arbiter_pkg.sv
// Shared types and helpers for the shift unit arbiter: operation/state encodings,
// datapath widths and the 32-bit bit-reversal used to build left shifts on a right shifter.
package shift_unit_pkg;

    localparam int SHIFT_WIDTH = 32;
    localparam int SHIFT_AMT_W = 5;

    typedef enum logic [1:0] {
        SRL  = 2'd0,
        SRA  = 2'd1,
        SLL  = 2'd2,
        ROTR = 2'd3
    } shift_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROT2 = 2'd1,
        HOLD = 2'd2
    } arb_state_t;

    function automatic logic [SHIFT_WIDTH-1:0] bit_reverse32(input logic [SHIFT_WIDTH-1:0] x);
        logic [SHIFT_WIDTH-1:0] r;
        for (int i = 0; i < SHIFT_WIDTH; i++) begin
            r[i] = x[SHIFT_WIDTH-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_unit_arbiter_if.sv
// Request/response bundle between NUM_REQ requesters and the shift unit arbiter.
// master = requester side, slave = arbiter side.
interface shift_unit_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [32*NUM_REQ-1:0] req_data;
    logic [5*NUM_REQ-1:0]  req_amount;
    logic [2*NUM_REQ-1:0]  req_op;
    logic [NUM_REQ-1:0]    resp_valid;
    logic [NUM_REQ-1:0]    resp_ready;
    logic [31:0]           resp_data;

    modport master (
        output req_valid, req_data, req_amount, req_op, resp_ready,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_data, req_amount, req_op, resp_ready,
        output req_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/shift_unit_arbiter_bsr.sv
// BitShiftRight: single 32-bit right barrel shifter with a selectable fill bit.
module BitShiftRight
    import shift_unit_pkg::*;
(
    input  logic [SHIFT_WIDTH-1:0] in_i,
    input  logic [SHIFT_AMT_W-1:0] amt_i,
    input  logic                   fill_i,
    output logic [SHIFT_WIDTH-1:0] out_o
);

    logic [2*SHIFT_WIDTH-1:0] ext_s;

    // Shift a fill-extended copy so vacated bits take the fill value.
    always_comb begin
        ext_s = {{SHIFT_WIDTH{fill_i}}, in_i} >> amt_i;
        out_o = ext_s[SHIFT_WIDTH-1:0];
    end

endmodule

// File: rtl/shift_unit_arbiter.sv
// Round-robin arbiter sharing one right shifter among NUM_REQ requesters; ROTR takes two passes.
// Optional statistics counters are enabled with SHIFT_UNIT_ARBITER_STATS_EN.
module shift_unit_arbiter
    import shift_unit_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int RR_INIT = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    shift_unit_arbiter_if.slave   bus,
`ifdef SHIFT_UNIT_ARBITER_STATS_EN
    output logic [16*NUM_REQ-1:0] grant_count,
    output logic [15:0]           stall_count,
`endif
    output logic                  busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0] RR_RST = IDX_W'(RR_INIT);
    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_ROT2 = ROT2;
    localparam logic [1:0] ST_HOLD = HOLD;

    function automatic logic [NUM_REQ-1:0] to_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] oh;
        for (int k = 0; k < NUM_REQ; k++) begin
            oh[k] = (idx == IDX_W'(k));
        end
        return oh;
    endfunction

    logic [SHIFT_WIDTH-1:0] data_a [NUM_REQ];
    logic [SHIFT_AMT_W-1:0] amt_a  [NUM_REQ];
    logic [1:0]             op_a   [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign data_a[k] = bus.req_data[k*SHIFT_WIDTH +: SHIFT_WIDTH];
        assign amt_a[k]  = bus.req_amount[k*SHIFT_AMT_W +: SHIFT_AMT_W];
        assign op_a[k]   = bus.req_op[k*2 +: 2];
    end

    logic [1:0]             state_q, state_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [SHIFT_WIDTH-1:0] x_q, x_d;
    logic [SHIFT_AMT_W-1:0] amt_q, amt_d;
    logic [SHIFT_WIDTH-1:0] part_q, part_d;
    logic [SHIFT_WIDTH-1:0] resp_data_q, resp_data_d;
    logic [NUM_REQ-1:0]     resp_valid_q, resp_valid_d;
    logic                   busy_q, busy_d;

    logic                   gnt_any_s, grant_s, drain_s;
    logic [IDX_W-1:0]       gnt_idx_s;
    logic [SHIFT_WIDTH-1:0] g_data_s;
    logic [SHIFT_AMT_W-1:0] g_amt_s;
    shift_op_t              g_op_s;
    logic [SHIFT_WIDTH-1:0] sh_in_s, sh_out_s, sh_rev_s;
    logic [SHIFT_AMT_W-1:0] sh_amt_s;
    logic                   sh_fill_s;

    // Round-robin search for the first valid requester at or after rr_ptr.
    always_comb begin
        int  idx;
        logic hit;
        idx       = 0;
        hit       = 1'b0;
        gnt_any_s = 1'b0;
        gnt_idx_s = {IDX_W{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            idx       = (int'(rr_ptr_q) + i) % NUM_REQ;
            hit       = !gnt_any_s && bus.req_valid[idx];
            gnt_idx_s = hit ? IDX_W'(idx) : gnt_idx_s;
            gnt_any_s = gnt_any_s | hit;
        end
    end

    assign drain_s       = (state_q == ST_HOLD) && bus.resp_ready[owner_q];
    assign grant_s       = rst_n && gnt_any_s && ((state_q == ST_IDLE) || drain_s);
    assign bus.req_ready = grant_s ? to_onehot(gnt_idx_s) : {NUM_REQ{1'b0}};

    assign g_data_s = data_a[gnt_idx_s];
    assign g_amt_s  = amt_a[gnt_idx_s];
    assign g_op_s   = shift_op_t'(op_a[gnt_idx_s]);

    // Shifter operand mux; ROT2 computes x << (32-n) as rev(rev(x) >> -n).
    always_comb begin
        if (state_q == ST_ROT2) begin
            sh_in_s   = bit_reverse32(x_q);
            sh_amt_s  = 5'd0 - amt_q;
            sh_fill_s = 1'b0;
        end else begin
            sh_in_s   = (g_op_s == SLL) ? bit_reverse32(g_data_s) : g_data_s;
            sh_amt_s  = g_amt_s;
            sh_fill_s = (g_op_s == SRA) ? g_data_s[SHIFT_WIDTH-1] : 1'b0;
        end
    end

    BitShiftRight u_bsr (
        .in_i   (sh_in_s),
        .amt_i  (sh_amt_s),
        .fill_i (sh_fill_s),
        .out_o  (sh_out_s)
    );

    assign sh_rev_s = bit_reverse32(sh_out_s);

    // Next-state logic: a grant from IDLE or a draining HOLD both launch the new operation.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        rr_ptr_d     = rr_ptr_q;
        x_d          = x_q;
        amt_d        = amt_q;
        part_d       = part_q;
        resp_data_d  = resp_data_q;
        resp_valid_d = resp_valid_q;
        case (state_q)
            ST_IDLE, ST_HOLD: begin
                if (grant_s) begin
                    owner_d  = gnt_idx_s;
                    rr_ptr_d = IDX_W'((int'(gnt_idx_s) + 1) % NUM_REQ);
                    x_d      = g_data_s;
                    amt_d    = g_amt_s;
                    if (g_op_s == ROTR) begin
                        part_d       = sh_out_s;
                        state_d      = ST_ROT2;
                        resp_valid_d = {NUM_REQ{1'b0}};
                    end else begin
                        resp_data_d  = (g_op_s == SLL) ? sh_rev_s : sh_out_s;
                        state_d      = ST_HOLD;
                        resp_valid_d = to_onehot(gnt_idx_s);
                    end
                end else if (drain_s) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = {NUM_REQ{1'b0}};
                end else begin
                    state_d      = state_q;
                end
            end
            ST_ROT2: begin
                resp_data_d  = part_q | sh_rev_s;
                state_d      = ST_HOLD;
                resp_valid_d = to_onehot(owner_q);
            end
            default: begin
                state_d      = ST_IDLE;
                resp_valid_d = {NUM_REQ{1'b0}};
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= {IDX_W{1'b0}};
            rr_ptr_q     <= RR_RST;
            x_q          <= {SHIFT_WIDTH{1'b0}};
            amt_q        <= {SHIFT_AMT_W{1'b0}};
            part_q       <= {SHIFT_WIDTH{1'b0}};
            resp_data_q  <= {SHIFT_WIDTH{1'b0}};
            resp_valid_q <= {NUM_REQ{1'b0}};
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            rr_ptr_q     <= rr_ptr_d;
            x_q          <= x_d;
            amt_q        <= amt_d;
            part_q       <= part_d;
            resp_data_q  <= resp_data_d;
            resp_valid_q <= resp_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign busy           = busy_q;

`ifdef SHIFT_UNIT_ARBITER_STATS_EN
    logic [15:0] grant_cnt_q [NUM_REQ];
    logic [15:0] stall_cnt_q;
    logic        stall_s;

    assign stall_s = (|bus.req_valid) && !grant_s;

    // Saturating per-requester grant counters and contention stall counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                grant_cnt_q[k] <= 16'd0;
            end
            stall_cnt_q <= 16'd0;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (grant_s && (gnt_idx_s == IDX_W'(k)) && (grant_cnt_q[k] != 16'hFFFF)) begin
                    grant_cnt_q[k] <= grant_cnt_q[k] + 16'd1;
                end
            end
            if (stall_s && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_stats
        assign grant_count[16*k +: 16] = grant_cnt_q[k];
    end
    assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// Directed self-checking bench for shift_unit_arbiter with two requesters and RR_INIT=0.
module tb_shift_unit_arbiter;
    import shift_unit_pkg::*;

    localparam int NUM_REQ = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;
    int   n_checks = 0;
    int   n_errors = 0;

    shift_unit_arbiter_if #(.NUM_REQ(NUM_REQ)) ifc ();

`ifdef SHIFT_UNIT_ARBITER_STATS_EN
    logic [16*NUM_REQ-1:0] grant_count;
    logic [15:0]           stall_count;
`endif

    shift_unit_arbiter #(.NUM_REQ(NUM_REQ), .RR_INIT(0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc),
`ifdef SHIFT_UNIT_ARBITER_STATS_EN
        .grant_count (grant_count),
        .stall_count (stall_count),
`endif
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [31:0] d, input logic [4:0] n, input logic [1:0] op);
        ifc.req_data[32*k +: 32] = d;
        ifc.req_amount[5*k +: 5] = n;
        ifc.req_op[2*k +: 2]     = op;
    endtask

    initial begin
        logic [1:0] exp_g;
        rst_n          = 1'b0;
        ifc.req_valid  = 2'b00;
        ifc.req_data   = 64'd0;
        ifc.req_amount = 10'd0;
        ifc.req_op     = 4'd0;
        ifc.resp_ready = 2'b00;
        tick();
        tick();
        check_eq("rst_resp_valid", 32'(ifc.resp_valid), 32'h0);
        check_eq("rst_resp_data", ifc.resp_data, 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_req_ready", 32'(ifc.req_ready), 32'h0);
        rst_n = 1'b1;
        ifc.resp_ready = 2'b11;
        tick();

        // SRL then back-to-back SRA on req0
        set_req(0, 32'hF000_0000, 5'd4, SRL);
        ifc.req_valid = 2'b01;
        #1;
        check_eq("srl_ready", 32'(ifc.req_ready), 32'h1);
        tick();
        check_eq("srl_valid", 32'(ifc.resp_valid), 32'h1);
        check_eq("srl_data", ifc.resp_data, 32'h0F00_0000);
        check_eq("srl_busy", 32'(busy), 32'h1);
        set_req(0, 32'hF000_0000, 5'd4, SRA);
        #1;
        check_eq("sra_b2b_ready", 32'(ifc.req_ready), 32'h1);
        tick();
        ifc.req_valid = 2'b00;
        check_eq("sra_valid", 32'(ifc.resp_valid), 32'h1);
        check_eq("sra_data", ifc.resp_data, 32'hFF00_0000);
        tick();
        check_eq("drain_valid", 32'(ifc.resp_valid), 32'h0);
        check_eq("drain_busy", 32'(busy), 32'h0);

        // SLL then ROTR on req1, req0 waiting during ROT2
        set_req(1, 32'h0000_0001, 5'd31, SLL);
        ifc.req_valid = 2'b10;
        #1;
        check_eq("sll_ready", 32'(ifc.req_ready), 32'h2);
        tick();
        check_eq("sll_valid", 32'(ifc.resp_valid), 32'h2);
        check_eq("sll_data", ifc.resp_data, 32'h8000_0000);
        set_req(1, 32'h0000_00F1, 5'd4, ROTR);
        tick();
        set_req(0, 32'h8000_0000, 5'd31, SRL);
        ifc.req_valid = 2'b01;
        #1;
        check_eq("rot2_busy", 32'(busy), 32'h1);
        check_eq("rot2_valid", 32'(ifc.resp_valid), 32'h0);
        check_eq("rot2_ready", 32'(ifc.req_ready), 32'h0);
        tick();
        check_eq("rotr_valid", 32'(ifc.resp_valid), 32'h2);
        check_eq("rotr_data", ifc.resp_data, 32'h1000_000F);
        check_eq("rotr_busy", 32'(busy), 32'h1);
        check_eq("rotr_b2b_ready", 32'(ifc.req_ready), 32'h1);
        tick();
        ifc.req_valid = 2'b00;
        check_eq("srl31_data", ifc.resp_data, 32'h0000_0001);
        check_eq("srl31_valid", 32'(ifc.resp_valid), 32'h1);
        tick();

        // Alternating grants; rr pointer now favours req1
        set_req(0, 32'h1234_5678, 5'd8, SRL);
        set_req(1, 32'h1234_5678, 5'd8, SLL);
        ifc.req_valid = 2'b11;
        exp_g = 2'b10;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq("rr_ready", 32'(ifc.req_ready), 32'(exp_g));
            tick();
            check_eq("rr_valid", 32'(ifc.resp_valid), 32'(exp_g));
            check_eq("rr_data", ifc.resp_data, (exp_g == 2'b01) ? 32'h0012_3456 : 32'h3456_7800);
            exp_g = ~exp_g;
        end

        // Owner req0 stalls; req1's resp_ready is a non-owner bit and must be ignored
        ifc.resp_ready = 2'b10;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq("stall_ready", 32'(ifc.req_ready), 32'h0);
            check_eq("stall_valid", 32'(ifc.resp_valid), 32'h1);
            check_eq("stall_data", ifc.resp_data, 32'h0012_3456);
            tick();
        end
        ifc.resp_ready = 2'b01;
        #1;
        check_eq("drain_b2b_ready", 32'(ifc.req_ready), 32'h2);
        tick();
        ifc.req_valid  = 2'b00;
        ifc.resp_ready = 2'b11;
        check_eq("drain_b2b_valid", 32'(ifc.resp_valid), 32'h2);
        check_eq("drain_b2b_data", ifc.resp_data, 32'h3456_7800);
        tick();

        // ROTR by zero returns the operand
        set_req(0, 32'hDEAD_BEEF, 5'd0, ROTR);
        ifc.req_valid = 2'b01;
        tick();
        ifc.req_valid = 2'b00;
        tick();
        check_eq("rotr0_valid", 32'(ifc.resp_valid), 32'h1);
        check_eq("rotr0_data", ifc.resp_data, 32'hDEAD_BEEF);
        tick();

        // Reset during ROT2; rr pointer would favour req1 without the reset
        set_req(0, 32'h0000_00F1, 5'd4, ROTR);
        ifc.req_valid = 2'b01;
        tick();
        ifc.req_valid = 2'b00;
        check_eq("rst_mid_busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_eq("rst_mid_valid", 32'(ifc.resp_valid), 32'h0);
        check_eq("rst_mid_busy0", 32'(busy), 32'h0);
        set_req(0, 32'h0000_0010, 5'd1, SRL);
        set_req(1, 32'h0000_0010, 5'd2, SRL);
        ifc.req_valid = 2'b11;
        #1;
        check_eq("rst_rr_ptr", 32'(ifc.req_ready), 32'h1);
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        check_eq("five_owner", 32'(ifc.resp_valid), 32'h1);
        check_eq("five_data", ifc.resp_data, 32'h0000_0008);
        ifc.req_valid  = 2'b10;
        ifc.resp_ready = 2'b00;
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        ifc.req_valid = 2'b00;
`ifdef SHIFT_UNIT_ARBITER_STATS_EN
        check_eq("grant_count0", 32'(grant_count[15:0]), 32'd3);
        check_eq("grant_count1", 32'(grant_count[31:16]), 32'd2);
        check_eq("stall_count", 32'(stall_count), 32'd4);
`endif
        check_eq("end_hold_valid", 32'(ifc.resp_valid), 32'h1);
        ifc.resp_ready = 2'b11;
        tick();
        check_eq("end_idle_busy", 32'(busy), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
